// File: rtl/butterfly_stage_ctrl.sv
// butterfly_stage_ctrl
// Sequences one 128-butterfly NTT stage over a 256-entry coefficient RAM.
// The block issues one read pair per cycle, presents the matching zeta index,
// and writes the butterfly results back two cycles after each read.
// hold_i freezes the whole read/write pipeline in place.
// Index maths uses shifts and masks only. The group length is a power of two,
// so k/len and k%len reduce to a shift and a mask.

module butterfly_stage_ctrl #(
   parameter int W = 23
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         mode_i,
   input  logic [2:0]   stage_i,
   input  logic         hold_i,
   output logic [7:0]   rd_addr_a_o,
   output logic [7:0]   rd_addr_b_o,
   output logic         rd_en_o,
   output logic [7:0]   twiddle_idx_o,
   output logic         sel_butterfly_o,
   input  logic [W-1:0] res_a_i,
   input  logic [W-1:0] res_b_i,
   output logic [7:0]   wr_addr_a_o,
   output logic [7:0]   wr_addr_b_o,
   output logic [W-1:0] wr_data_a_o,
   output logic [W-1:0] wr_data_b_o,
   output logic         wr_en_o,
   output logic         busy_o,
   output logic         done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [6:0] K_LAST = 7'd127;

   // Returns {a, b, twiddle} for butterfly k.
   // Forward (CT) uses len = 128>>s. Inverse (GS) uses len = 1<<s.
   // Forward twiddle is (1<<s)+g. Because g < 2^s, that sum equals (1<<s)|g.
   // Inverse twiddle is (256>>s)-1-g. Because g < 2^(7-s), that equals (0xFF>>s)^g.
   function automatic logic [23:0] index_calc(input logic [6:0] k,
                                               input logic       m,
                                               input logic [2:0] s);
      logic [2:0] lg;
      logic [7:0] len;
      logic [7:0] mask;
      logic [7:0] kk;
      logic [7:0] o;
      logic [7:0] g;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] tw;
      if (m) begin
         lg = s;
      end else begin
         lg = 3'd7 - s;
      end
      len  = 8'd1 << lg;
      mask = len - 8'd1;
      kk   = {1'b0, k};
      o    = kk & mask;
      g    = kk >> lg;
      // 2*g*len is simply the group bits of k moved up by one position
      a    = ((kk & ~mask) << 1) | o;
      // bit lg of a is always clear, so adding len is an OR
      b    = a | len;
      if (m) begin
         tw = (8'hFF >> s) ^ g;
      end else begin
         tw = (8'd1 << s) | g;
      end
      return {a, b, tw};
   endfunction

   state_t         state_r;
   state_t         state_nxt_s;
   logic [6:0]     k_r;
   logic           mode_r;
   logic [2:0]     stage_r;

   logic           rd_vld_r;
   logic [7:0]     rd_addr_a_r;
   logic [7:0]     rd_addr_b_r;
   logic [7:0]     tw_r;

   logic           p1_vld_r;
   logic [7:0]     p1_addr_a_r;
   logic [7:0]     p1_addr_b_r;

   logic           wr_vld_r;
   logic [7:0]     wr_addr_a_r;
   logic [7:0]     wr_addr_b_r;
   logic [W-1:0]   wr_data_a_r;
   logic [W-1:0]   wr_data_b_r;

   logic           busy_r;
   logic           done_r;

   logic           start_acc_s;
   logic           issue_s;
   logic           last_issue_s;
   logic           wr_fire_s;
   logic [6:0]     calc_k_s;
   logic           calc_mode_s;
   logic [2:0]     calc_stage_s;
   logic [23:0]    calc_s;

   // Pipeline strobes and the index set for the next butterfly to present
   always_comb begin
      start_acc_s  = 1'b0;
      issue_s      = 1'b0;
      last_issue_s = 1'b0;
      wr_fire_s    = 1'b0;
      calc_k_s     = 7'd0;
      calc_mode_s  = 1'b0;
      calc_stage_s = 3'd0;
      calc_s       = 24'd0;

      start_acc_s  = (state_r == IDLE) && start_i;
      issue_s      = rd_vld_r && !hold_i;
      last_issue_s = issue_s && (k_r == K_LAST);
      wr_fire_s    = wr_vld_r && !hold_i;
      // On start the first butterfly is built from the live inputs, so the read lands in the very next cycle
      if (start_acc_s) begin
         calc_k_s     = 7'd0;
         calc_mode_s  = mode_i;
         calc_stage_s = stage_i;
      end else begin
         calc_k_s     = k_r + 7'd1;
         calc_mode_s  = mode_r;
         calc_stage_s = stage_r;
      end
      calc_s = index_calc(calc_k_s, calc_mode_s, calc_stage_s);
   end

   // Next-state logic: hold only delays transitions through the strobes above
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (last_issue_s) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            // The last write is the one that fires with nothing left behind it
            if (wr_fire_s && !p1_vld_r) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Read issue stage: latch the pass configuration and step k one butterfly per unstalled cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         k_r         <= 7'd0;
         mode_r      <= 1'b0;
         stage_r     <= 3'd0;
         rd_vld_r    <= 1'b0;
         rd_addr_a_r <= 8'd0;
         rd_addr_b_r <= 8'd0;
         tw_r        <= 8'd0;
      end else if (start_acc_s) begin
         k_r         <= 7'd0;
         mode_r      <= mode_i;
         stage_r     <= stage_i;
         rd_vld_r    <= 1'b1;
         rd_addr_a_r <= calc_s[23:16];
         rd_addr_b_r <= calc_s[15:8];
         tw_r        <= calc_s[7:0];
      end else if (issue_s) begin
         k_r <= k_r + 7'd1;
         if (last_issue_s) begin
            rd_vld_r <= 1'b0;
         end else begin
            rd_vld_r    <= 1'b1;
            rd_addr_a_r <= calc_s[23:16];
            rd_addr_b_r <= calc_s[15:8];
            tw_r        <= calc_s[7:0];
         end
      end
   end

   // Address/valid pipeline and write registers; everything freezes while hold_i is high
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         p1_vld_r    <= 1'b0;
         p1_addr_a_r <= 8'd0;
         p1_addr_b_r <= 8'd0;
         wr_vld_r    <= 1'b0;
         wr_addr_a_r <= 8'd0;
         wr_addr_b_r <= 8'd0;
         wr_data_a_r <= {W{1'b0}};
         wr_data_b_r <= {W{1'b0}};
      end else if (!hold_i) begin
         p1_vld_r <= issue_s;
         if (issue_s) begin
            p1_addr_a_r <= rd_addr_a_r;
            p1_addr_b_r <= rd_addr_b_r;
         end
         wr_vld_r <= p1_vld_r;
         if (p1_vld_r) begin
            wr_addr_a_r <= p1_addr_a_r;
            wr_addr_b_r <= p1_addr_b_r;
            wr_data_a_r <= res_a_i;
            wr_data_b_r <= res_b_i;
         end
      end
   end

   // Status flags follow the state being entered, so they change together with it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != IDLE);
         done_r <= (state_nxt_s == DONE);
      end
   end

   // The enables are gated by hold_i directly. This takes them low in the same cycle the stall is raised.
   assign rd_en_o         = rd_vld_r && !hold_i;
   assign wr_en_o         = wr_vld_r && !hold_i;
   assign rd_addr_a_o     = rd_addr_a_r;
   assign rd_addr_b_o     = rd_addr_b_r;
   assign twiddle_idx_o   = tw_r;
   assign sel_butterfly_o = mode_r;
   assign wr_addr_a_o     = wr_addr_a_r;
   assign wr_addr_b_o     = wr_addr_b_r;
   assign wr_data_a_o     = wr_data_a_r;
   assign wr_data_b_o     = wr_data_b_r;
   assign busy_o          = busy_r;
   assign done_o          = done_r;

endmodule

// File: tb/tb_butterfly_stage_ctrl.sv
// Testbench for butterfly_stage_ctrl.
// A behavioural RAM and butterfly drive res_a_i/res_b_i. A software NTT index
// model fills read and write scoreboards at each start. A negedge monitor pops
// the scoreboards and compares them against every read and every write.

module tb_butterfly_stage_ctrl;

   localparam int W = 23;

   typedef struct packed {
      logic [7:0]   a;
      logic [7:0]   b;
      logic [7:0]   tw;
      logic [W-1:0] da;
      logic [W-1:0] db;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         start_i;
   logic         mode_i;
   logic [2:0]   stage_i;
   logic         hold_i;
   logic [7:0]   rd_addr_a_o;
   logic [7:0]   rd_addr_b_o;
   logic         rd_en_o;
   logic [7:0]   twiddle_idx_o;
   logic         sel_butterfly_o;
   logic [W-1:0] res_a_i;
   logic [W-1:0] res_b_i;
   logic [7:0]   wr_addr_a_o;
   logic [7:0]   wr_addr_b_o;
   logic [W-1:0] wr_data_a_o;
   logic [W-1:0] wr_data_b_o;
   logic         wr_en_o;
   logic         busy_o;
   logic         done_o;

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;
   int base     = 0;
   int rd_cnt, wr_cnt, first_rd, last_rd, first_wr, last_wr;
   int hits[256];
   bit exp_mode;
   exp_t rdq[$];
   exp_t wrq[$];

   logic [W-1:0] qa, qb;
   logic [7:0]   qtw;

   always #5 clk = ~clk;

   butterfly_stage_ctrl #(.W(W)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
      .stage_i(stage_i), .hold_i(hold_i),
      .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .rd_en_o(rd_en_o),
      .twiddle_idx_o(twiddle_idx_o), .sel_butterfly_o(sel_butterfly_o),
      .res_a_i(res_a_i), .res_b_i(res_b_i),
      .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o),
      .wr_data_a_o(wr_data_a_o), .wr_data_b_o(wr_data_b_o), .wr_en_o(wr_en_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   function automatic logic [W-1:0] mem_val(input int i);
      return W'(i * 40503 + 12345);
   endfunction

   // Reference NTT index model written with ordinary division and modulo
   function automatic exp_t model(input bit m, input int s, input int k);
      exp_t e;
      int len, g, o, a, b, tw;
      len = m ? (1 << s) : (128 >> s);
      g   = k / len;
      o   = k % len;
      a   = 2 * g * len + o;
      b   = a + len;
      tw  = m ? ((256 >> s) - 1 - g) : ((1 << s) + g);
      e.a  = 8'(a);
      e.b  = 8'(b);
      e.tw = 8'(tw);
      e.da = mem_val(a) + W'(tw);
      e.db = mem_val(b) ^ W'(tw);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Synchronous RAM with one-cycle latency feeding a simple butterfly stand-in
   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (rd_en_o) begin
         qa  <= mem_val(int'(rd_addr_a_o));
         qb  <= mem_val(int'(rd_addr_b_o));
         qtw <= twiddle_idx_o;
      end
   end
   assign res_a_i = qa + W'(qtw);
   assign res_b_i = qb ^ W'(qtw);

   // Monitor: compare every read and every write against the scoreboards
   always @(negedge clk) begin
      exp_t e;
      int rel;
      if (!rst_i) begin
         rel = edge_cnt - base;
         if (hold_i) chk("hold_quiet", {rd_en_o, wr_en_o}, 2'b00);
         if (rd_en_o) begin
            if (rd_cnt == 0) first_rd = rel;
            last_rd = rel;
            rd_cnt++;
            chk("rd_expected", rdq.size() != 0, 1'b1);
            if (rdq.size() != 0) begin
               e = rdq.pop_front();
               chk("rd_a_b_tw", {rd_addr_a_o, rd_addr_b_o, twiddle_idx_o}, {e.a, e.b, e.tw});
            end
         end
         if (wr_en_o) begin
            if (wr_cnt == 0) first_wr = rel;
            last_wr = rel;
            wr_cnt++;
            hits[wr_addr_a_o]++;
            hits[wr_addr_b_o]++;
            chk("wr_expected", wrq.size() != 0, 1'b1);
            if (wrq.size() != 0) begin
               e = wrq.pop_front();
               chk("wr_addr_data", {wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o},
                   {e.a, e.b, e.da, e.db});
            end
         end
         if (busy_o) chk("sel_butterfly", sel_butterfly_o, exp_mode);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      rdq.delete();
      wrq.delete();
      rd_cnt = 0; wr_cnt = 0;
      first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
      for (int i = 0; i < 256; i++) hits[i] = 0;
   endtask

   task automatic do_start(input bit m, input logic [2:0] s);
      clear_sb();
      for (int k = 0; k < 128; k++) begin
         rdq.push_back(model(m, int'(s), k));
         wrq.push_back(model(m, int'(s), k));
      end
      exp_mode = m;
      mode_i   = m;
      stage_i  = s;
      start_i  = 1'b1;
      base     = edge_cnt;
      step();
      start_i  = 1'b0;
      mode_i   = ~m;
      stage_i  = s + 3'd3;
   endtask

   task automatic end_pass(input string tag, input int exp_done, input int l_rd,
                           input int l_wr);
      int n;
      int bad;
      n = 0;
      while (!done_o && n < 400) begin
         step();
         n++;
      end
      chk({tag, "_done_seen"}, done_o, 1'b1);
      chk({tag, "_done_cycle"}, edge_cnt - base, exp_done);
      step();
      chk({tag, "_done_pulse_idle"}, {done_o, busy_o}, 2'b00);
      chk({tag, "_rd_wr_count"}, {32'(rd_cnt), 32'(wr_cnt)}, {32'd128, 32'd128});
      chk({tag, "_rd_window"}, {32'(first_rd), 32'(last_rd)}, {32'd1, 32'(l_rd)});
      chk({tag, "_wr_window"}, {32'(first_wr), 32'(last_wr)}, {32'd3, 32'(l_wr)});
      bad = 0;
      for (int i = 0; i < 256; i++) if (hits[i] != 1) bad++;
      chk({tag, "_each_addr_once"}, bad, 0);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; stage_i = 3'd0; hold_i = 1'b0;
      exp_mode = 1'b0;
      clear_sb();
      step(); step();
      chk("reset_outputs", {rd_addr_a_o, rd_addr_b_o, rd_en_o, twiddle_idx_o, sel_butterfly_o,
          wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o, wr_en_o, busy_o, done_o}, 128'd0);
      rst_i = 1'b0;
      step();

      // forward s=0: k=0 -> a=0 b=128 tw=1
      do_start(1'b0, 3'd0);
      chk("fwd0_first", {busy_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, twiddle_idx_o},
          {1'b1, 1'b1, 8'd0, 8'd128, 8'd1});
      end_pass("fwd0", 131, 128, 130);

      // forward s=7: k=0 -> a=0 b=1 tw=128
      do_start(1'b0, 3'd7);
      chk("fwd7_first", {rd_addr_a_o, rd_addr_b_o, twiddle_idx_o}, {8'd0, 8'd1, 8'd128});
      end_pass("fwd7", 131, 128, 130);

      // inverse s=0: k=0 -> a=0 b=1 tw=255
      do_start(1'b1, 3'd0);
      chk("inv0_first", {rd_addr_a_o, rd_addr_b_o, twiddle_idx_o}, {8'd0, 8'd1, 8'd255});
      end_pass("inv0", 131, 128, 130);

      // inverse s=7: a=k, b=k+128; zeta index (256>>7)-1-0 = 1
      do_start(1'b1, 3'd7);
      chk("inv7_first", {rd_addr_a_o, rd_addr_b_o, twiddle_idx_o, sel_butterfly_o},
          {8'd0, 8'd128, 8'd1, 1'b1});
      end_pass("inv7", 131, 128, 130);

      // five-cycle stall starting at cycle 10
      do_start(1'b0, 3'd3);
      while (edge_cnt - base < 10) step();
      hold_i = 1'b1;
      repeat (5) step();
      hold_i = 1'b0;
      end_pass("hold", 136, 133, 135);

      // reset at cycle 50 aborts the pass
      do_start(1'b1, 3'd2);
      while (edge_cnt - base < 50) step();
      rst_i = 1'b1;
      #1;
      chk("midreset_outputs", {rd_addr_a_o, rd_addr_b_o, rd_en_o, twiddle_idx_o, sel_butterfly_o,
          wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o, wr_en_o, busy_o, done_o}, 128'd0);
      step();
      clear_sb();
      rst_i = 1'b0;
      repeat (20) step();
      chk("postreset_no_writes", {32'(wr_cnt), 32'(rd_cnt)}, 64'd0);
      do_start(1'b0, 3'd1);
      chk("fresh_first", {rd_addr_a_o, rd_addr_b_o, twiddle_idx_o}, {8'd0, 8'd64, 8'd2});
      end_pass("fresh", 131, 128, 130);

      // start re-pulsed mid-pass with different mode/stage is ignored
      do_start(1'b0, 3'd2);
      while (edge_cnt - base < 20) step();
      start_i = 1'b1; mode_i = 1'b1; stage_i = 3'd5;
      step();
      start_i = 1'b0;
      end_pass("restart", 131, 128, 130);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
